ula_sequencial: RTL and testbench

//   Parametrised signed ALU with accumulator; successor of the single-cycle 7-bit operacoes block.

---
 rtl/ula_sequencial.sv | 174 +++++++++++++++++
 tb/tb_ula_sequencial.sv | 319 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ula_sequencial.sv
// Signed ALU with a 2W-bit accumulator: single-cycle add/sub/load ops plus an
// iterative shift-add MUL/MAC, sticky overflow, optional saturation and LED outputs.
module ula_sequencial #(
    parameter int W   = 7,
    parameter bit SAT = 1'b0
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            start,
    input  logic [2:0]      opcode,
    input  logic [W-1:0]    op1,
    input  logic [W-1:0]    op2,
    output logic            busy,
    output logic            done,
    output logic [2*W-1:0]  q,
    output logic            overflow,
    output logic            led_sinal,
    output logic [2*W-1:0]  led_valor
);

    localparam int QW = 2 * W;
    localparam int CW = $clog2(W + 1);

    localparam logic [2:0] OP_LOAD  = 3'd0;
    localparam logic [2:0] OP_ADD   = 3'd1;
    localparam logic [2:0] OP_SUB   = 3'd2;
    localparam logic [2:0] OP_MUL   = 3'd3;
    localparam logic [2:0] OP_CLEAR = 3'd4;
    localparam logic [2:0] OP_MAC   = 3'd5;
    localparam logic [2:0] OP_ADDQ  = 3'd6;

    localparam logic [QW-1:0] Q_MAX = {1'b0, {(QW-1){1'b1}}};
    localparam logic [QW-1:0] Q_MIN = {1'b1, {(QW-1){1'b0}}};

    typedef enum logic [1:0] {IDLE, MULT, FIN} state_t;

    // Handshake: a request is taken on any posedge with start=1 while busy=0;
    // done is a registered one-cycle pulse per accepted request.
    state_t          state;
    state_t          state_next;
    logic            accept;
    logic            is_multi;
    logic [CW-1:0]   cnt;
    logic [QW-1:0]   a_sh;
    logic [W-1:0]    b_sh;
    logic [QW-1:0]   pp;
    logic            neg;
    logic            is_mac;

    logic [QW-1:0]   ext1;
    logic [QW-1:0]   ext2;
    logic [W-1:0]    abs1;
    logic [W-1:0]    abs2;
    logic [QW-1:0]   prod_signed;
    logic [QW-1:0]   add_b;
    logic [QW-1:0]   add_sum;
    logic            add_ovf;
    logic [QW-1:0]   add_res;

    assign accept   = start && (state == IDLE);
    assign is_multi = (opcode == OP_MUL) || (opcode == OP_MAC);

    assign ext1 = {{W{op1[W-1]}}, op1};
    assign ext2 = {{W{op2[W-1]}}, op2};
    // The magnitude of -2^(W-1) is 2^(W-1), which still fits W unsigned bits.
    assign abs1 = op1[W-1] ? -op1 : op1;
    assign abs2 = op2[W-1] ? -op2 : op2;

    assign prod_signed = neg ? -pp : pp;

    // Shared accumulate adder: MAC adds the product at FIN, ADDQ adds ext(op2).
    assign add_b   = (state == FIN) ? prod_signed : ext2;
    assign add_sum = q + add_b;
    assign add_ovf = (q[QW-1] == add_b[QW-1]) && (add_sum[QW-1] != q[QW-1]);
    assign add_res = (SAT && add_ovf) ? (q[QW-1] ? Q_MIN : Q_MAX) : add_sum;

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_next;
    end

    // Next-state logic
    always_comb begin
        state_next = state;
        case (state)
            IDLE: if (accept && is_multi) state_next = MULT;
            MULT: if (cnt == CW'(W - 1)) state_next = FIN;
            FIN:  state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Output logic
    always_comb begin
        busy = (state != IDLE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q        <= '0;
            overflow <= 1'b0;
            done     <= 1'b0;
            cnt      <= '0;
            a_sh     <= '0;
            b_sh     <= '0;
            pp       <= '0;
            neg      <= 1'b0;
            is_mac   <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (accept) begin
                        case (opcode)
                            OP_LOAD: begin
                                q        <= ext2;
                                overflow <= 1'b0;
                                done     <= 1'b1;
                            end
                            OP_ADD: begin
                                q    <= ext1 + ext2;
                                done <= 1'b1;
                            end
                            OP_SUB: begin
                                q    <= ext1 - ext2;
                                done <= 1'b1;
                            end
                            OP_CLEAR: begin
                                q        <= '0;
                                overflow <= 1'b0;
                                done     <= 1'b1;
                            end
                            OP_ADDQ: begin
                                q <= add_res;
                                if (add_ovf) overflow <= 1'b1;
                                done <= 1'b1;
                            end
                            OP_MUL, OP_MAC: begin
                                a_sh   <= {{W{1'b0}}, abs1};
                                b_sh   <= abs2;
                                pp     <= '0;
                                cnt    <= '0;
                                neg    <= op1[W-1] ^ op2[W-1];
                                is_mac <= (opcode == OP_MAC);
                            end
                            default: done <= 1'b1;
                        endcase
                    end
                end
                MULT: begin
                    if (b_sh[0]) pp <= pp + a_sh;
                    a_sh <= a_sh << 1;
                    b_sh <= b_sh >> 1;
                    cnt  <= cnt + 1'b1;
                end
                FIN: begin
                    if (is_mac) begin
                        q <= add_res;
                        if (add_ovf) overflow <= 1'b1;
                    end else begin
                        q <= prod_signed;
                    end
                    done <= 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign led_sinal = q[QW-1];
    assign led_valor = q[QW-1] ? -q : q;

endmodule

// File: tb/tb_ula_sequencial.sv
// Directed bench for ula_sequencial: W=7 wrap, W=7 saturating and W=4 instances.
module tb_ula_sequencial;

    logic        clk;
    logic        rst_n;

    // W=7 instances share stimulus
    logic        start;
    logic [2:0]  opcode;
    logic [6:0]  op1;
    logic [6:0]  op2;
    logic        busy, done, overflow, led_sinal;
    logic [13:0] q, led_valor;
    logic        busy_s, done_s, overflow_s, led_sinal_s;
    logic [13:0] q_s, led_valor_s;

    // W=4 instance
    logic        start4;
    logic [2:0]  opcode4;
    logic [3:0]  a4;
    logic [3:0]  b4;
    logic        busy4, done4, overflow4, led_sinal4;
    logic [7:0]  q4, led_valor4;

    int n_cmp = 0;
    int n_err = 0;

    ula_sequencial #(.W(7), .SAT(1'b0)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .opcode(opcode), .op1(op1), .op2(op2),
        .busy(busy), .done(done), .q(q), .overflow(overflow),
        .led_sinal(led_sinal), .led_valor(led_valor)
    );

    ula_sequencial #(.W(7), .SAT(1'b1)) dut_sat (
        .clk(clk), .rst_n(rst_n), .start(start), .opcode(opcode), .op1(op1), .op2(op2),
        .busy(busy_s), .done(done_s), .q(q_s), .overflow(overflow_s),
        .led_sinal(led_sinal_s), .led_valor(led_valor_s)
    );

    ula_sequencial #(.W(4), .SAT(1'b0)) dut4 (
        .clk(clk), .rst_n(rst_n), .start(start4), .opcode(opcode4), .op1(a4), .op2(b4),
        .busy(busy4), .done(done4), .q(q4), .overflow(overflow4),
        .led_sinal(led_sinal4), .led_valor(led_valor4)
    );

    // Clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Drivers: request at a negedge, return at the negedge after the accept edge
    task automatic issue(input int opc, input int a, input int b);
        @(negedge clk);
        start  = 1'b1;
        opcode = 3'(opc);
        op1    = 7'(a);
        op2    = 7'(b);
        @(negedge clk);
        start  = 1'b0;
    endtask

    task automatic wait_idle(output int n);
        n = 0;
        while (busy === 1'b1 && n < 40) begin
            n++;
            @(negedge clk);
        end
    endtask

    task automatic issue4(input int opc, input int a, input int b);
        @(negedge clk);
        start4  = 1'b1;
        opcode4 = 3'(opc);
        a4      = 4'(a);
        b4      = 4'(b);
        @(negedge clk);
        start4  = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        start = 0; opcode = 0; op1 = 0; op2 = 0;
        start4 = 0; opcode4 = 0; a4 = 0; b4 = 0;
        repeat (2) @(negedge clk);
        n_cmp++;
        if ({q, busy, done, overflow} !== {14'd0, 3'b000}) begin
            n_err++;
            $display("FAIL reset_state: got q=%h busy=%b done=%b ovf=%b, want 0", q, busy, done, overflow);
        end
        rst_n = 1'b1;
        @(negedge clk);
        n_cmp++;
        if ({q4, busy4, done4, overflow4, led_sinal, led_valor} !== {8'd0, 3'b000, 1'b0, 14'd0}) begin
            n_err++;
            $display("FAIL reset_after_release: got q4=%h busy4=%b done4=%b sinal=%b valor=%h",
                     q4, busy4, done4, led_sinal, led_valor);
        end
    endtask

    task automatic test_single_ops();
        issue(1, 5, -3);
        n_cmp++;
        if ({q, done, busy, overflow} !== {14'd2, 3'b100}) begin
            n_err++;
            $display("FAIL add_5_m3: got q=%h done=%b busy=%b ovf=%b, want q=0002 done=1 busy=0 ovf=0",
                     q, done, busy, overflow);
        end
        @(negedge clk);
        n_cmp++;
        if (done !== 1'b0) begin
            n_err++;
            $display("FAIL add_done_pulse: got done=%b want 0", done);
        end
        issue(2, 5, -3);
        n_cmp++;
        if (q !== 14'd8) begin
            n_err++;
            $display("FAIL sub_5_m3: got q=%h want 0008", q);
        end
        issue(0, 0, 63);
        issue(6, 0, -3);
        n_cmp++;
        if ({q, overflow} !== {14'd60, 1'b0}) begin
            n_err++;
            $display("FAIL addq_63_m3: got q=%h ovf=%b want 003c 0", q, overflow);
        end
        issue(7, 11, 22);
        n_cmp++;
        if ({q, done} !== {14'd60, 1'b1}) begin
            n_err++;
            $display("FAIL nop_hold: got q=%h done=%b want 003c 1", q, done);
        end
    endtask

    task automatic test_mul();
        int n;
        issue(3, 7, -3);
        wait_idle(n);
        n_cmp++;
        if (n !== 8) begin
            n_err++;
            $display("FAIL mul_busy_len: got %0d cycles want 8", n);
        end
        n_cmp++;
        if ({q, done, led_sinal, led_valor} !== {14'h3FEB, 1'b1, 1'b1, 14'd21}) begin
            n_err++;
            $display("FAIL mul_7_m3: got q=%h done=%b sinal=%b valor=%0d want 3feb 1 1 21",
                     q, done, led_sinal, led_valor);
        end
        @(negedge clk);
        n_cmp++;
        if (done !== 1'b0) begin
            n_err++;
            $display("FAIL mul_done_pulse: got done=%b want 0", done);
        end
    endtask

    task automatic test_mac_overflow();
        int n;
        issue(4, 0, 0);
        issue(3, -64, -64);
        wait_idle(n);
        n_cmp++;
        if ({q, q_s} !== {14'd4096, 14'd4096}) begin
            n_err++;
            $display("FAIL mul_m64_m64: got q=%h q_sat=%h want 1000", q, q_s);
        end
        issue(5, -64, -64);
        wait_idle(n);
        n_cmp++;
        if ({q, overflow, led_valor} !== {14'h2000, 1'b1, 14'h2000}) begin
            n_err++;
            $display("FAIL mac_wrap: got q=%h ovf=%b valor=%h want 2000 1 2000", q, overflow, led_valor);
        end
        n_cmp++;
        if ({q_s, overflow_s} !== {14'h1FFF, 1'b1}) begin
            n_err++;
            $display("FAIL mac_sat: got q=%h ovf=%b want 1fff 1", q_s, overflow_s);
        end
        issue(1, 1, 1);
        n_cmp++;
        if ({q, overflow} !== {14'd2, 1'b1}) begin
            n_err++;
            $display("FAIL ovf_sticky: got q=%h ovf=%b want 0002 1", q, overflow);
        end
        issue(0, 0, 63);
        n_cmp++;
        if ({q, overflow, overflow_s} !== {14'd63, 1'b0, 1'b0}) begin
            n_err++;
            $display("FAIL load_clears_ovf: got q=%h ovf=%b ovf_sat=%b want 003f 0 0", q, overflow, overflow_s);
        end
        issue(0, 0, -64);
        issue(6, 0, -64);
        n_cmp++;
        if ({q, overflow} !== {14'h3F80, 1'b0}) begin
            n_err++;
            $display("FAIL addq_neg: got q=%h ovf=%b want 3f80 0", q, overflow);
        end
    endtask

    task automatic test_ignore_start();
        int n;
        issue(3, 3, 5);
        @(negedge clk);
        start = 1'b1; opcode = 3'd1; op1 = 7'd1; op2 = 7'd1;
        @(negedge clk);
        start = 1'b0;
        wait_idle(n);
        n_cmp++;
        if ({q, done} !== {14'd15, 1'b1}) begin
            n_err++;
            $display("FAIL ignore_start_mul: got q=%h done=%b want 000f 1", q, done);
        end
        @(negedge clk);
        n_cmp++;
        if ({q, done, busy} !== {14'd15, 1'b0, 1'b0}) begin
            n_err++;
            $display("FAIL ignore_start_not_queued: got q=%h done=%b busy=%b want 000f 0 0", q, done, busy);
        end
    endtask

    task automatic test_reset_mid_mult();
        int seen;
        issue(3, 7, -3);
        repeat (3) @(negedge clk);
        rst_n = 1'b0;
        #1;
        n_cmp++;
        if ({q, busy, overflow, done} !== {14'd0, 3'b000}) begin
            n_err++;
            $display("FAIL reset_mid_mult: got q=%h busy=%b ovf=%b done=%b want 0", q, busy, overflow, done);
        end
        @(negedge clk);
        rst_n = 1'b1;
        seen = 0;
        for (int i = 0; i < 15; i++) begin
            @(negedge clk);
            if (done === 1'b1 || busy === 1'b1) seen++;
        end
        n_cmp++;
        if (seen !== 0) begin
            n_err++;
            $display("FAIL reset_no_done: got %0d done/busy cycles want 0", seen);
        end
    endtask

    task automatic test_w4();
        int n;
        issue4(3, -8, -8);
        n = 0;
        while (busy4 === 1'b1 && n < 40) begin
            n++;
            @(negedge clk);
        end
        n_cmp++;
        if ({n[7:0], q4, done4} !== {8'd5, 8'd64, 1'b1}) begin
            n_err++;
            $display("FAIL w4_mul_m8_m8: got busy=%0d q=%h done=%b want 5 40 1", n, q4, done4);
        end
    endtask

    task automatic test_back_to_back();
        int n;
        @(negedge clk);
        start4 = 1'b1; opcode4 = 3'd3; a4 = 4'd2; b4 = 4'd3;
        @(negedge clk);
        n = 0;
        while (busy4 === 1'b1 && n < 40) begin
            n++;
            @(negedge clk);
        end
        n_cmp++;
        if ({q4, done4} !== {8'd6, 1'b1}) begin
            n_err++;
            $display("FAIL b2b_mul: got q=%h done=%b want 06 1", q4, done4);
        end
        opcode4 = 3'd1; a4 = 4'd3; b4 = 4'd4;
        @(negedge clk);
        n_cmp++;
        if ({q4, done4, busy4} !== {8'd7, 1'b1, 1'b0}) begin
            n_err++;
            $display("FAIL b2b_add_in_done_cycle: got q=%h done=%b busy=%b want 07 1 0", q4, done4, busy4);
        end
        a4 = 4'hE; b4 = 4'hB;
        @(negedge clk);
        start4 = 1'b0;
        n_cmp++;
        if ({q4, done4, led_sinal4, led_valor4} !== {8'hF9, 1'b1, 1'b1, 8'd7}) begin
            n_err++;
            $display("FAIL b2b_add_neg: got q=%h done=%b sinal=%b valor=%0d want f9 1 1 7",
                     q4, done4, led_sinal4, led_valor4);
        end
        @(negedge clk);
        n_cmp++;
        if (done4 !== 1'b0) begin
            n_err++;
            $display("FAIL b2b_done_drop: got done=%b want 0", done4);
        end
    endtask

    initial begin
        test_reset();
        test_single_ops();
        test_mul();
        test_mac_overflow();
        test_ignore_start();
        test_reset_mid_mult();
        test_w4();
        test_back_to_back();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
